// File: rtl/conv_seq_ctrl_if.sv
// Handshake bundle between the convolution sequencer and its datapath
// (weight loader, input FIFO, PE array, adder tree, output FIFO).
interface conv_seq_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic [CNT_WIDTH-1:0] num_windows;
    logic                 reload_w;
    logic                 weight_valid;
    logic                 wr_weight_en;
    logic                 wr_weight_done;
    logic                 in_tvalid;
    logic                 in_tready;
    logic                 pe_wr_dataIn_en;
    logic                 pe_array_done;
    logic                 adder_en;
    logic                 adder_done;
    logic                 out_tready;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] issued_cnt;
    logic                 err;

    modport master (
        input  start, num_windows, reload_w, weight_valid, wr_weight_done,
               in_tvalid, pe_array_done, adder_done, out_tready,
        output wr_weight_en, in_tready, pe_wr_dataIn_en, adder_en,
               busy, done, issued_cnt, err
    );

    modport slave (
        output start, num_windows, reload_w, weight_valid, wr_weight_done,
               in_tvalid, pe_array_done, adder_done, out_tready,
        input  wr_weight_en, in_tready, pe_wr_dataIn_en, adder_en,
               busy, done, issued_cnt, err
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for the convolution datapath: weight load, credit-limited
// window issue and drain.
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_LOAD_W | waiting for weight_valid, strobes wr_weight_en
//   S_WAIT_W | waiting for PE array weight load to finish
//   S_STREAM | popping windows while credits allow
//   S_DRAIN  | all windows issued, waiting for in-flight results
//   S_DONE   | one-cycle end-of-frame pulse
module conv_seq_ctrl #(
    parameter int CNT_WIDTH    = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    conv_seq_ctrl_if.master io_seq
);
    localparam int             IW     = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0]  LP_MAX = IW'(MAX_INFLIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WAIT_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_num_windows;
    logic [CNT_WIDTH-1:0] r_issued_cnt;
    logic [IW-1:0]        r_inflight;
    logic                 r_w_loaded;
    logic                 r_err;
    logic                 r_adder_en;

    logic w_accept;
    logic w_in_tready;
    logic w_fire;
    logic w_last_fire;
    logic w_wr_weight_en;

    always_comb begin
        w_accept       = (r_state == S_IDLE) && io_seq.start;
        w_in_tready    = (r_state == S_STREAM) && (r_issued_cnt < r_num_windows)
                         && (r_inflight < LP_MAX) && io_seq.out_tready;
        w_fire         = w_in_tready && io_seq.in_tvalid;
        w_last_fire    = w_fire && ((r_issued_cnt + CNT_WIDTH'(1)) == r_num_windows);
        w_wr_weight_en = (r_state == S_LOAD_W) && io_seq.weight_valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_seq.start) begin
                    if (io_seq.reload_w || !r_w_loaded)
                        w_state_nxt = S_LOAD_W;
                    else if (io_seq.num_windows == '0)
                        w_state_nxt = S_DONE;
                    else
                        w_state_nxt = S_STREAM;
                end
            end
            S_LOAD_W: begin
                if (io_seq.weight_valid)
                    w_state_nxt = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (io_seq.wr_weight_done)
                    w_state_nxt = (r_num_windows == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (w_last_fire)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_inflight == '0)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= S_IDLE;
            r_num_windows <= '0;
            r_issued_cnt  <= '0;
            r_inflight    <= '0;
            r_w_loaded    <= 1'b0;
            r_err         <= 1'b0;
            r_adder_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_adder_en <= io_seq.pe_array_done;

            if (w_accept) begin
                r_num_windows <= io_seq.num_windows;
                r_issued_cnt  <= '0;
            end else if (w_fire) begin
                r_issued_cnt  <= r_issued_cnt + CNT_WIDTH'(1);
            end

            // A return with nothing outstanding is flagged, never counted.
            if (w_accept)
                r_inflight <= '0;
            else if (w_fire && !io_seq.adder_done)
                r_inflight <= r_inflight + IW'(1);
            else if (!w_fire && io_seq.adder_done && (r_inflight != '0))
                r_inflight <= r_inflight - IW'(1);

            if (io_seq.adder_done && (r_inflight == '0))
                r_err <= 1'b1;
            else if (w_accept)
                r_err <= 1'b0;

            if ((r_state == S_WAIT_W) && io_seq.wr_weight_done)
                r_w_loaded <= 1'b1;
        end
    end

    assign io_seq.wr_weight_en    = w_wr_weight_en;
    assign io_seq.in_tready       = w_in_tready;
    assign io_seq.pe_wr_dataIn_en = w_fire;
    assign io_seq.adder_en        = r_adder_en;
    assign io_seq.busy            = (r_state != S_IDLE);
    assign io_seq.done            = (r_state == S_DONE);
    assign io_seq.issued_cnt      = r_issued_cnt;
    assign io_seq.err             = r_err;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed frame scenarios with
// randomized side inputs, checked every cycle against an event-level model.
module tb_conv_seq_ctrl;
    localparam int CW   = 16;
    localparam int MAXI = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.CNT_WIDTH(CW)) sif ();

    conv_seq_ctrl #(.CNT_WIDTH(CW), .MAX_INFLIGHT(MAXI)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_seq (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame bookkeeping in terms of events, not FSM states.
    int m_num, m_issued, m_inflight;
    bit m_active, m_loaded, m_need_w, m_wait, m_w_ok, m_err, m_pe_prev, m_cprev;

    int n_wen, n_fire, n_done, n_rdy;
    bit auto_ad, rand_tv, rand_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_num = 0; m_issued = 0; m_inflight = 0;
        m_active = 0; m_loaded = 0; m_need_w = 0; m_wait = 0; m_w_ok = 0;
        m_err = 0; m_pe_prev = 0; m_cprev = 0;
    endtask

    task automatic clr_counts();
        n_wen = 0; n_fire = 0; n_done = 0; n_rdy = 0;
    endtask

    task automatic drive_auto();
        sif.start          = rand_start && m_active && ($urandom_range(0, 7) == 0);
        sif.num_windows    = CW'($urandom_range(0, 20));
        sif.reload_w       = 1'($urandom_range(0, 1));
        sif.weight_valid   = ($urandom_range(0, 2) == 0);
        sif.wr_weight_done = ($urandom_range(0, 2) == 0);
        sif.pe_array_done  = 1'($urandom_range(0, 1));
        sif.adder_done     = auto_ad && (m_inflight > 0) && ($urandom_range(0, 1) == 1);
        if (rand_tv) begin
            sif.in_tvalid  = ($urandom_range(0, 3) != 0);
            sif.out_tready = ($urandom_range(0, 4) != 0);
        end
    endtask

    task automatic step();
        bit e_wen, e_rdy, e_fire, e_done, c_now, acc, was_wait, spur, fin;
        @(negedge clk);
        e_wen  = m_active && m_need_w && sif.weight_valid;
        e_rdy  = m_active && m_w_ok && (m_issued < m_num) && (m_inflight < MAXI) && sif.out_tready;
        e_fire = e_rdy && sif.in_tvalid;
        e_done = m_active && m_cprev && (m_num != 0);
        chk("wr_weight_en", sif.wr_weight_en, e_wen);
        chk("in_tready", sif.in_tready, e_rdy);
        chk("pe_wr_dataIn_en", sif.pe_wr_dataIn_en, e_fire);
        chk("adder_en", sif.adder_en, m_pe_prev);
        chk("busy", sif.busy, m_active);
        chk("issued_cnt", sif.issued_cnt, m_issued);
        chk("err", sif.err, m_err);
        if (!(m_active && m_num == 0))
            chk("done", sif.done, e_done);
        n_wen  += int'(sif.wr_weight_en);
        n_fire += int'(sif.pe_wr_dataIn_en);
        n_done += int'(sif.done);
        n_rdy  += int'(sif.in_tready);
        if (!rstn) begin
            model_reset();
        end else begin
            fin      = (m_active && m_num == 0) ? sif.done : e_done;
            c_now    = m_active && m_w_ok && (m_issued == m_num) && (m_inflight == 0) && !fin;
            acc      = sif.start && !m_active;
            was_wait = m_wait;
            spur     = sif.adder_done && (m_inflight == 0);
            if (fin) m_active = 0;
            if (e_wen) begin
                m_need_w = 0;
                m_wait   = 1;
            end
            if (was_wait && sif.wr_weight_done) begin
                m_wait   = 0;
                m_w_ok   = 1;
                m_loaded = 1;
            end
            if (e_fire) m_issued++;
            if (!spur) begin
                if (e_fire && !sif.adder_done) m_inflight++;
                else if (!e_fire && sif.adder_done) m_inflight--;
            end
            if (acc) begin
                m_active   = 1;
                m_num      = int'(sif.num_windows);
                m_issued   = 0;
                m_inflight = 0;
                m_err      = 0;
                m_need_w   = sif.reload_w || !m_loaded;
                m_w_ok     = !m_need_w;
                m_wait     = 0;
            end
            if (spur) m_err = 1;
            m_cprev = c_now;
        end
        m_pe_prev = rstn ? sif.pe_array_done : 1'b0;
        @(posedge clk);
        #1;
        drive_auto();
    endtask

    task automatic start_frame(input int num, input bit reload);
        sif.start       = 1'b1;
        sif.num_windows = CW'(num);
        sif.reload_w    = reload;
        sif.adder_done  = 1'b0;
        step();
    endtask

    task automatic run_to_idle(input int budget);
        int k = 0;
        while (m_active && k < budget) begin
            step();
            k++;
        end
        chk("frame_timeout_busy", sif.busy, 1'b0);
    endtask

    initial begin
        int f0, nw;
        rstn = 1'b0;
        sif.start = 0; sif.num_windows = '0; sif.reload_w = 0;
        sif.weight_valid = 0; sif.wr_weight_done = 0; sif.in_tvalid = 0;
        sif.pe_array_done = 0; sif.adder_done = 0; sif.out_tready = 1;
        auto_ad = 0; rand_tv = 0; rand_start = 0;
        model_reset();
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        step();

        // Frame A: reload, five windows
        auto_ad = 1; sif.in_tvalid = 1; sif.out_tready = 1;
        clr_counts();
        start_frame(5, 1'b1);
        run_to_idle(300);
        chk("A_wen_pulses", n_wen, 1);
        chk("A_fires", n_fire, 5);
        chk("A_done_pulses", n_done, 1);
        chk("A_issued_final", sif.issued_cnt, 5);

        // Frame B: weights kept, straight to streaming
        clr_counts();
        start_frame(3, 1'b0);
        chk("B_busy_after_start", sif.busy, 1'b1);
        chk("B_tready_after_start", sif.in_tready, 1'b1);
        run_to_idle(300);
        chk("B_wen_pulses", n_wen, 0);
        chk("B_fires", n_fire, 3);
        chk("B_issued_final", sif.issued_cnt, 3);

        // Credit limit with no returns, then one return frees one slot
        auto_ad = 0;
        clr_counts();
        start_frame(10, 1'b0);
        repeat (8) step();
        chk("C_fires_at_cap", n_fire, MAXI);
        chk("C_tready_at_cap", sif.in_tready, 1'b0);
        sif.adder_done = 1'b1;
        step();
        repeat (4) step();
        chk("C_one_more_fire", n_fire, MAXI + 1);
        auto_ad = 1;
        run_to_idle(400);
        chk("C_fires_total", n_fire, 10);

        // Output backpressure stalls issue only
        clr_counts();
        start_frame(8, 1'b0);
        repeat (2) step();
        f0 = n_fire;
        sif.out_tready = 1'b0;
        repeat (10) step();
        chk("D_stall_no_fires", n_fire - f0, 0);
        sif.out_tready = 1'b1;
        run_to_idle(400);
        chk("D_fires_total", n_fire, 8);

        // Zero-length frame with weights loaded
        clr_counts();
        start_frame(0, 1'b0);
        repeat (2) step();
        chk("Z_done_pulses", n_done, 1);
        chk("Z_tready_cycles", n_rdy, 0);
        chk("Z_idle_after", sif.busy, 1'b0);

        // Spurious return mid-stream: flagged, credits untouched
        auto_ad = 0;
        sif.in_tvalid = 1'b0;
        clr_counts();
        start_frame(6, 1'b0);
        step();
        sif.adder_done = 1'b1;
        step();
        chk("E_err_set", sif.err, 1'b1);
        sif.in_tvalid = 1'b1;
        repeat (8) step();
        chk("E_fires_after_spurious", n_fire, MAXI);

        // Reset while streaming
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("R_busy", sif.busy, 1'b0);
        chk("R_in_tready", sif.in_tready, 1'b0);
        chk("R_pe_wr", sif.pe_wr_dataIn_en, 1'b0);
        chk("R_wr_weight_en", sif.wr_weight_en, 1'b0);
        chk("R_adder_en", sif.adder_en, 1'b0);
        chk("R_done", sif.done, 1'b0);
        chk("R_issued_cnt", sif.issued_cnt, 0);
        chk("R_err", sif.err, 1'b0);
        step();
        auto_ad = 1;
        clr_counts();
        start_frame(2, 1'b0);
        run_to_idle(300);
        chk("F_reload_after_reset", n_wen, 1);
        chk("F_fires", n_fire, 2);

        // Randomized frames
        rand_tv = 1; rand_start = 1;
        repeat (12) begin
            nw = $urandom_range(1, 12);
            clr_counts();
            start_frame(nw, 1'($urandom_range(0, 1)));
            run_to_idle(600);
            chk("RND_fires", n_fire, nw);
            chk("RND_done_pulses", n_done, 1);
        end
        rand_tv = 0; rand_start = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
